// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake with a one-entry skid buffer
// so in_ready_o comes straight from a flop, plus flush and a stall counter.
module id_ex_pipe_reg #(
  parameter int DATA_W      = 8,
  parameter int REG_W       = 3,
  parameter int ALUOP_W     = 4,
  parameter int OPC_W       = 4,
  parameter int IMM_W       = 3,
  parameter int JMP_W       = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   flush_i,
  input  logic [ALUOP_W-1:0]     alu_op_i,
  output logic [ALUOP_W-1:0]     alu_op_o,
  input  logic                   write_mem_i,
  output logic                   write_mem_o,
  input  logic                   write_reg_i,
  output logic                   write_reg_o,
  input  logic                   read_mem_i,
  output logic                   read_mem_o,
  input  logic [DATA_W-1:0]      data1_i,
  output logic [DATA_W-1:0]      data1_o,
  input  logic [DATA_W-1:0]      data2_i,
  output logic [DATA_W-1:0]      data2_o,
  input  logic [DATA_W-1:0]      dataD_i,
  output logic [DATA_W-1:0]      dataD_o,
  input  logic [REG_W-1:0]       reg1_i,
  output logic [REG_W-1:0]       reg1_o,
  input  logic [REG_W-1:0]       reg2_i,
  output logic [REG_W-1:0]       reg2_o,
  input  logic [REG_W-1:0]       regD_i,
  output logic [REG_W-1:0]       regD_o,
  input  logic [JMP_W-1:0]       jmpLoc_i,
  output logic [JMP_W-1:0]       jmpLoc_o,
  input  logic [OPC_W-1:0]       opcode_i,
  output logic [OPC_W-1:0]       opcode_o,
  input  logic [IMM_W-1:0]       imm_i,
  output logic [IMM_W-1:0]       imm_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int PAY_W = ALUOP_W + 3 + 3*DATA_W + 3*REG_W + JMP_W + OPC_W + IMM_W;

  logic [PAY_W-1:0] in_pay, m_pay, s_pay;
  logic             m_valid, s_valid, in_ready_q;
  logic             m_valid_d, s_valid_d;
  logic             m_load, m_from_s, s_load;
  logic             accept, drain, stall_inc;
  logic             wm_q, wr_q, rm_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign in_pay = {alu_op_i, write_mem_i, write_reg_i, read_mem_i,
                   data1_i, data2_i, dataD_i, reg1_i, reg2_i, regD_i,
                   jmpLoc_i, opcode_i, imm_i};

  assign accept    = in_valid_i & in_ready_q;
  assign drain     = m_valid & out_ready_i;
  assign stall_inc = m_valid & ~out_ready_i & ~flush_i;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    m_load    = 1'b0;
    m_from_s  = 1'b0;
    s_load    = 1'b0;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid || drain) begin
      if (s_valid) begin
        // accept is always 0 here because in_ready_q mirrors ~s_valid.
        m_from_s  = 1'b1;
        m_valid_d = 1'b1;
        s_valid_d = accept;
        s_load    = accept;
      end else begin
        m_valid_d = accept;
        m_load    = accept;
      end
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid    <= m_valid_d;
      s_valid    <= s_valid_d;
      in_ready_q <= ~s_valid_d;
    end
  end

  // NOTE: payload flops are reset too, so outputs are deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pay <= '0;
      s_pay <= '0;
    end else begin
      if (m_from_s)    m_pay <= s_pay;
      else if (m_load) m_pay <= in_pay;
      if (s_load)      s_pay <= in_pay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall_inc && ~&stall_cnt)   stall_cnt <= stall_cnt + 1'b1;
  end

  assign {alu_op_o, wm_q, wr_q, rm_q, data1_o, data2_o, dataD_o,
          reg1_o, reg2_o, regD_o, jmpLoc_o, opcode_o, imm_o} = m_pay;

  // Strobes are gated by valid so a bubble can never write regfile or memory.
  assign write_mem_o = wm_q & m_valid;
  assign write_reg_o = wr_q & m_valid;
  assign read_mem_o  = rm_q & m_valid;
  assign out_valid_o = m_valid;
  assign in_ready_o  = in_ready_q;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg: directed scenarios plus random traffic against a
// two-deep FIFO reference model; a second instance has a 3-bit stall counter.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        wm, wr, rm;
    logic [7:0]  d1, d2, dd;
    logic [2:0]  r1, r2, rd;
    logic [15:0] jmp;
    logic [3:0]  opc;
    logic [2:0]  imm;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready, flush;
  pl_t  pin;

  logic        in_ready, out_valid;
  logic [3:0]  alu_op_o, opcode_o;
  logic        wm_o, wr_o, rm_o;
  logic [7:0]  d1_o, d2_o, dd_o;
  logic [2:0]  r1_o, r2_o, rd_o, imm_o;
  logic [15:0] jmp_o, stall_cnt;
  pl_t         out_pl;

  logic        s_in_ready, s_out_valid;
  logic [3:0]  s_alu_op_o, s_opcode_o;
  logic        s_wm_o, s_wr_o, s_rm_o;
  logic [7:0]  s_d1_o, s_d2_o, s_dd_o;
  logic [2:0]  s_r1_o, s_r2_o, s_rd_o, s_imm_o;
  logic [15:0] s_jmp_o;
  logic [2:0]  s_stall_cnt;
  pl_t         sat_pl;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of at most two instructions plus a stall tally.
  pl_t q[$];
  int  stall_m = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .flush_i(flush),
    .alu_op_i(pin.alu_op), .alu_op_o(alu_op_o),
    .write_mem_i(pin.wm), .write_mem_o(wm_o),
    .write_reg_i(pin.wr), .write_reg_o(wr_o),
    .read_mem_i(pin.rm), .read_mem_o(rm_o),
    .data1_i(pin.d1), .data1_o(d1_o), .data2_i(pin.d2), .data2_o(d2_o),
    .dataD_i(pin.dd), .dataD_o(dd_o),
    .reg1_i(pin.r1), .reg1_o(r1_o), .reg2_i(pin.r2), .reg2_o(r2_o),
    .regD_i(pin.rd), .regD_o(rd_o),
    .jmpLoc_i(pin.jmp), .jmpLoc_o(jmp_o), .opcode_i(pin.opc), .opcode_o(opcode_o),
    .imm_i(pin.imm), .imm_o(imm_o), .stall_cnt_o(stall_cnt)
  );

  id_ex_pipe_reg #(.STALL_CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .flush_i(flush),
    .alu_op_i(pin.alu_op), .alu_op_o(s_alu_op_o),
    .write_mem_i(pin.wm), .write_mem_o(s_wm_o),
    .write_reg_i(pin.wr), .write_reg_o(s_wr_o),
    .read_mem_i(pin.rm), .read_mem_o(s_rm_o),
    .data1_i(pin.d1), .data1_o(s_d1_o), .data2_i(pin.d2), .data2_o(s_d2_o),
    .dataD_i(pin.dd), .dataD_o(s_dd_o),
    .reg1_i(pin.r1), .reg1_o(s_r1_o), .reg2_i(pin.r2), .reg2_o(s_r2_o),
    .regD_i(pin.rd), .regD_o(s_rd_o),
    .jmpLoc_i(pin.jmp), .jmpLoc_o(s_jmp_o), .opcode_i(pin.opc), .opcode_o(s_opcode_o),
    .imm_i(pin.imm), .imm_o(s_imm_o), .stall_cnt_o(s_stall_cnt)
  );

  assign out_pl = {alu_op_o, wm_o, wr_o, rm_o, d1_o, d2_o, dd_o,
                   r1_o, r2_o, rd_o, jmp_o, opcode_o, imm_o};
  assign sat_pl = {s_alu_op_o, s_wm_o, s_wr_o, s_rm_o, s_d1_o, s_d2_o, s_dd_o,
                   s_r1_o, s_r2_o, s_rd_o, s_jmp_o, s_opcode_o, s_imm_o};

  function automatic pl_t rand_pl();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return pl_t'(r[$bits(pl_t)-1:0]);
  endfunction

  // Update the model from the inputs presented now, then advance one clock and
  // return at the following falling edge, where outputs are sampled.
  task automatic advance();
    bit acc, drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && !flush) stall_m++;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(pin);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    stall_m = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; pin = rand_pl(); pin.wr = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_reg: got %b expected 0", wr_o); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    n_checks++; if (out_pl !== pl_t'('0)) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", out_pl); end
    rst_n = 1'b1; q.delete(); stall_m = 0;
    pin.d1 = 8'hA5;
    advance();
    n_checks++; if (out_valid !== 1'b1 || d1_o !== 8'hA5 || wr_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_accept: got v=%b d1=%h wr=%b expected v=1 d1=a5 wr=1", out_valid, d1_o, wr_o);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    advance();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; pin = rand_pl(); pin.d1 = 8'h11 + 8'(i);
      advance();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || d1_o !== 8'h11 + 8'(i)) begin
        n_fail++; $display("FAIL stream_%0d: got rdy=%b v=%b d1=%h expected rdy=1 v=1 d1=%h", i, in_ready, out_valid, d1_o, 8'h11 + 8'(i));
      end
    end
    in_valid = 1'b0;
    advance();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int base;
    base = stall_m;
    out_ready = 1'b0;
    in_valid = 1'b1; pin = rand_pl(); pin.alu_op = 4'd3;
    advance();
    n_checks++; if (in_ready !== 1'b1 || alu_op_o !== 4'd3) begin n_fail++; $display("FAIL bp_after_a: got rdy=%b op=%0d expected rdy=1 op=3", in_ready, alu_op_o); end
    pin = rand_pl(); pin.alu_op = 4'd5;
    advance();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    pin = rand_pl(); pin.alu_op = 4'd7;
    advance();
    advance();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_op_o !== 4'd3) begin
      n_fail++; $display("FAIL bp_hold: got rdy=%b v=%b op=%0d expected rdy=0 v=1 op=3", in_ready, out_valid, alu_op_o);
    end
    n_checks++; if (stall_cnt !== 16'(base + 3)) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, base + 3); end
    out_ready = 1'b1;
    advance();
    n_checks++; if (alu_op_o !== 4'd5 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got op=%0d rdy=%b expected op=5 rdy=1", alu_op_o, in_ready); end
    advance();
    n_checks++; if (alu_op_o !== 4'd7 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_c: got op=%0d v=%b expected op=7 v=1", alu_op_o, out_valid); end
    in_valid = 1'b0;
    advance();
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'(base + 3)) begin
      n_fail++; $display("FAIL bp_end: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, stall_cnt, base + 3);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; pin = rand_pl(); pin.wm = 1'b1;
      advance();
    end
    n_checks++; if (in_ready !== 1'b0 || wm_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got rdy=%b wm=%b expected rdy=0 wm=1", in_ready, wm_o); end
    flush = 1'b1; pin = rand_pl();
    advance();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || wm_o !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_post: got v=%b wm=%b rdy=%b expected v=0 wm=0 rdy=1", out_valid, wm_o, in_ready);
    end
    out_ready = 1'b1;
    advance(); advance();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_replay: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_bubble_gating();
    pl_t x;
    out_ready = 1'b0;
    in_valid = 1'b1; x = rand_pl(); x.wr = 1'b1; pin = x;
    advance();
    n_checks++; if (wr_o !== 1'b1) begin n_fail++; $display("FAIL bubble_pre: got wr=%b expected 1", wr_o); end
    in_valid = 1'b0; flush = 1'b1;
    advance();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (wr_o !== 1'b0 || out_valid !== 1'b0 || d1_o !== x.d1) begin
        n_fail++; $display("FAIL bubble_%0d: got wr=%b v=%b d1=%h expected wr=0 v=0 d1=%h", i, wr_o, out_valid, d1_o, x.d1);
      end
      advance();
    end
  endtask

  task automatic test_random();
    int sat;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      pin       = rand_pl();
      advance();
      sat = (stall_m > 7) ? 7 : stall_m;
      n_checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rand_hs_%0d: got v=%b rdy=%b expected v=%b rdy=%b", c, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      n_checks++; if (stall_cnt !== 16'(stall_m) || s_stall_cnt !== 3'(sat)) begin
        n_fail++; $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt, s_stall_cnt, stall_m, sat);
      end
      if (q.size() > 0) begin
        n_checks++; if (out_pl !== q[0] || sat_pl !== q[0]) begin
          n_fail++; $display("FAIL rand_pl_%0d: got %h expected %h", c, out_pl, q[0]);
        end
      end else begin
        n_checks++; if ({wm_o, wr_o, rm_o, s_wm_o, s_wr_o, s_rm_o} !== 6'b0) begin
          n_fail++; $display("FAIL rand_gate_%0d: got strobes %b expected 0", c, {wm_o, wr_o, rm_o});
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    advance(); advance();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; pin = rand_pl(); pin.wm = 1'b1;
    advance();
    in_valid = 1'b0;
    repeat (12) advance();
    n_checks++; if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'd12) begin
      n_fail++; $display("FAIL sat_12: got %0d/%0d expected 7/12", s_stall_cnt, stall_cnt);
    end
    repeat (3) advance();
    n_checks++; if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'd15) begin
      n_fail++; $display("FAIL sat_hold: got %0d/%0d expected 7/15", s_stall_cnt, stall_cnt);
    end
    // Asynchronous reset in the middle of a stall, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || wm_o !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0 || s_stall_cnt !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: got v=%b wm=%b rdy=%b cnt=%0d/%0d expected 0 0 1 0/0", out_valid, wm_o, in_ready, stall_cnt, s_stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; q.delete(); stall_m = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; pin = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble_gating();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
